alu_issue_queue: RTL and testbench

//  Initiator side of the ALU_Unit operand/result interface. Accepts decoded ALU ops over valid/ready and buffers them in a FIFO.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_op_fifo.sv | 60 ++++++
 rtl/alu_issue_queue.sv | 129 ++++++++++++
 tb/tb_alu_issue_queue.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : ALUControl encodings, default widths and the op/writeback records
//            shared by the ALU issue queue.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int c_DATA_W = 32;
   localparam int c_TAG_W  = 5;

   localparam logic [3:0] c_ALU_ADD = 4'b0000;
   localparam logic [3:0] c_ALU_SUB = 4'b0001;
   localparam logic [3:0] c_ALU_AND = 4'b0010;
   localparam logic [3:0] c_ALU_OR  = 4'b0011;
   localparam logic [3:0] c_ALU_XOR = 4'b0100;
   localparam logic [3:0] c_ALU_SLT = 4'b0101;
   localparam logic [3:0] c_ALU_SLL = 4'b0110;
   localparam logic [3:0] c_ALU_SRL = 4'b0111;

   typedef struct packed {
      logic [3:0]          alu_ctrl;
      logic                alu_src;
      logic                ss_src;
      logic [c_DATA_W-1:0] src_a;
      logic [c_DATA_W-1:0] write_data;
      logic [c_DATA_W-1:0] imm;
      logic [c_TAG_W-1:0]  rd;
   } alu_op_t;

   typedef struct packed {
      logic [c_TAG_W-1:0]  rd;
      logic [c_DATA_W-1:0] data;
      logic                zero;
   } alu_wb_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_fifo
// Brief    : Synchronous FIFO of decoded ALU ops; full/empty from an extra
//            pointer wrap bit.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  alu_op_t                  push_data,
   input  logic                     pop,
   output alu_op_t                  pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_AW = $clog2(DEPTH);

   alu_op_t         r_mem [DEPTH];
   logic [c_AW:0]   r_wr_ptr;
   logic [c_AW:0]   r_rd_ptr;
   logic            w_do_push;
   logic            w_do_pop;

   assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign count     = r_wr_ptr - r_rd_ptr;
   assign pop_data  = r_mem[r_rd_ptr[c_AW-1:0]];
   assign w_do_push = push && !full && !flush;
   assign w_do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; only the pointers define occupancy.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_queue
// Brief    : Op FIFO -> issue register (drives ALU_Unit) -> writeback register.
//            Define ISSUE_BYPASS_EN to let an op enter the issue register
//            directly when the FIFO is empty.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_queue
   import alu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = c_DATA_W,
   parameter int TAG_W  = c_TAG_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_alu_ctrl,
   input  logic                     in_alu_src,
   input  logic                     in_ss_src,
   input  logic [DATA_W-1:0]        in_src_a,
   input  logic [DATA_W-1:0]        in_write_data,
   input  logic [DATA_W-1:0]        in_imm,
   input  logic [TAG_W-1:0]         in_rd,
   output logic [3:0]               alu_ctrl,
   output logic                     alu_src,
   output logic                     ss_src,
   output logic [DATA_W-1:0]        src_a,
   output logic [DATA_W-1:0]        write_data,
   output logic [DATA_W-1:0]        imm_ext,
   input  logic [DATA_W-1:0]        alu_result,
   input  logic                     alu_zero,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [TAG_W-1:0]         wb_rd,
   output logic [DATA_W-1:0]        wb_data,
   output logic                     wb_zero,
   output logic [$clog2(DEPTH):0]   count
);

   alu_op_t w_in_op;
   alu_op_t w_head;
   alu_op_t r_iss;
   alu_wb_t r_wb;
   logic    r_iss_valid;
   logic    r_wb_valid;
   logic    w_full;
   logic    w_empty;
   logic    w_accept;
   logic    w_iss_adv;
   logic    w_iss_load;
   logic    w_pop;
   logic    w_bypass;
   logic    w_fifo_push;

   assign w_in_op = '{alu_ctrl:   in_alu_ctrl,   alu_src: in_alu_src, ss_src: in_ss_src,
                      src_a:      in_src_a,      write_data: in_write_data,
                      imm:        in_imm,        rd: in_rd};

   assign in_ready    = !w_full;
   assign w_accept    = in_valid && !w_full && !flush;
   assign w_iss_adv   = !r_wb_valid || wb_ready;
   assign w_iss_load  = !r_iss_valid || w_iss_adv;
   assign w_pop       = !w_empty && w_iss_load && !flush;

`ifdef ISSUE_BYPASS_EN
   assign w_bypass    = w_accept && w_empty && w_iss_load;
`else
   assign w_bypass    = 1'b0;
`endif

   assign w_fifo_push = w_accept && !w_bypass;

   alu_op_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (w_fifo_push),
      .push_data (w_in_op),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .count     (count)
   );

   // Issue register: operand fields only change when a new op is loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_iss_valid <= 1'b0;
         r_iss       <= '0;
      end else if (flush) begin
         r_iss_valid <= 1'b0;
      end else if (w_iss_load) begin
         r_iss_valid <= w_pop || w_bypass;
         if (w_pop)         r_iss <= w_head;
         else if (w_bypass) r_iss <= w_in_op;
      end
   end

   // rd==0 ops still pass through this stage but never raise wb_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_valid <= 1'b0;
         r_wb       <= '0;
      end else if (flush) begin
         r_wb_valid <= 1'b0;
      end else if (w_iss_adv) begin
         r_wb_valid <= r_iss_valid && (r_iss.rd != '0);
         if (r_iss_valid) r_wb <= '{rd: r_iss.rd, data: alu_result, zero: alu_zero};
      end
   end

   assign alu_ctrl   = r_iss.alu_ctrl;
   assign alu_src    = r_iss.alu_src;
   assign ss_src     = r_iss.ss_src;
   assign src_a      = r_iss.src_a;
   assign write_data = r_iss.write_data;
   assign imm_ext    = r_iss.imm;
   assign wb_valid   = r_wb_valid;
   assign wb_rd      = r_wb.rd;
   assign wb_data    = r_wb.data;
   assign wb_zero    = r_wb.zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_queue
// Brief    : Randomized and directed bench for alu_issue_queue with an
//            in-order expected-result queue as reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_queue;
   import alu_pkg::*;

   localparam int DEPTH = 4;
`ifdef ISSUE_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_alu_ctrl = '0;
   logic        in_alu_src = 1'b0;
   logic        in_ss_src = 1'b0;
   logic [31:0] in_src_a = '0;
   logic [31:0] in_write_data = '0;
   logic [31:0] in_imm = '0;
   logic [4:0]  in_rd = '0;
   logic [3:0]  alu_ctrl;
   logic        alu_src;
   logic        ss_src;
   logic [31:0] src_a;
   logic [31:0] write_data;
   logic [31:0] imm_ext;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_zero;
   logic [2:0]  count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(32), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_ctrl(in_alu_ctrl), .in_alu_src(in_alu_src), .in_ss_src(in_ss_src),
      .in_src_a(in_src_a), .in_write_data(in_write_data), .in_imm(in_imm), .in_rd(in_rd),
      .alu_ctrl(alu_ctrl), .alu_src(alu_src), .ss_src(ss_src),
      .src_a(src_a), .write_data(write_data), .imm_ext(imm_ext),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_zero(wb_zero), .count(count)
   );

   // Stand-in for ALU_Unit: scalar ops, SIMD byte-lane add/sub.
   function automatic logic [31:0] alu_f(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic ss);
      logic [31:0] r;
      r = '0;
      if (ss && (c == c_ALU_ADD || c == c_ALU_SUB)) begin
         for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = (c == c_ALU_ADD) ? a[i*8 +: 8] + b[i*8 +: 8] : a[i*8 +: 8] - b[i*8 +: 8];
      end else begin
         case (c)
            c_ALU_ADD: r = a + b;
            c_ALU_SUB: r = a - b;
            c_ALU_AND: r = a & b;
            c_ALU_OR:  r = a | b;
            c_ALU_XOR: r = a ^ b;
            c_ALU_SLT: r = {31'b0, ($signed(a) < $signed(b))};
            c_ALU_SLL: r = a << b[4:0];
            c_ALU_SRL: r = a >> b[4:0];
            default:   r = '0;
         endcase
      end
      return r;
   endfunction

   always_comb begin
      alu_result = alu_f(alu_ctrl, src_a, alu_src ? imm_ext : write_data, ss_src);
      alu_zero   = (alu_result == '0);
   end

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        zero;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   logic        prev_stall = 1'b0;
   logic [4:0]  prev_rd;
   logic [31:0] prev_data;
   logic [31:0] r_exp;

   // Reference: every accepted op with rd!=0 must come out once, in order.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         tests++;
         if (in_ready !== (count != 3'(DEPTH)) || count > 3'(DEPTH)) begin
            fails++;
            $display("FAIL ready_vs_count: in_ready=%0b count=%0d", in_ready, count);
         end
         if (prev_stall) begin
            tests++;
            if (wb_valid !== 1'b1 || wb_rd !== prev_rd || wb_data !== prev_data) begin
               fails++;
               $display("FAIL wb_hold: valid=%0b rd=%0d data=%h required rd=%0d data=%h",
                        wb_valid, wb_rd, wb_data, prev_rd, prev_data);
            end
         end
         if (wb_valid && wb_ready) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL wb_extra: rd=%0d data=%h with nothing outstanding", wb_rd, wb_data);
            end else begin
               e = q.pop_front();
               if (wb_rd !== e.rd || wb_data !== e.data || wb_zero !== e.zero) begin
                  fails++;
                  $display("FAIL wb_result: rd=%0d data=%h zero=%0b required rd=%0d data=%h zero=%0b",
                           wb_rd, wb_data, wb_zero, e.rd, e.data, e.zero);
               end
            end
         end
         if (flush) begin
            q.delete();
         end else if (in_valid && in_ready && in_rd != 5'd0) begin
            r_exp = alu_f(in_alu_ctrl, in_src_a, in_alu_src ? in_imm : in_write_data, in_ss_src);
            q.push_back('{rd: in_rd, data: r_exp, zero: (r_exp == '0)});
         end
         prev_stall = wb_valid && !wb_ready && !flush;
         prev_rd    = wb_rd;
         prev_data  = wb_data;
      end
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(logic [3:0] c, logic asrc, logic ss, logic [31:0] a,
                         logic [31:0] wd, logic [31:0] im, logic [4:0] rd);
      in_alu_ctrl   = c;
      in_alu_src    = asrc;
      in_ss_src     = ss;
      in_src_a      = a;
      in_write_data = wd;
      in_imm        = im;
      in_rd         = rd;
   endtask

   task automatic rand_op(logic allow_rd0);
      logic [4:0] rd;
      rd = 5'($urandom_range(1, 31));
      if (allow_rd0 && $urandom_range(0, 7) == 0) rd = 5'd0;
      set_op(4'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom, $urandom, $urandom, rd);
   endtask

   task automatic drain(string name);
      int k;
      k = 0;
      while ((q.size() != 0 || wb_valid) && k < 100) begin
         tick();
         k++;
      end
      chk(name, 64'(q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int acc;
      int lat;
      logic saw_wb;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_count",    64'(count),    64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_wb_rd",    64'(wb_rd),    64'd0);
      chk("rst_wb_data",  64'(wb_data),  64'd0);
      chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
      chk("rst_src_a",    64'(src_a),    64'd0);
      rst_n = 1'b1;
      tick();

      // Single ADD 5+7 -> rd 3
      wb_ready = 1'b1;
      set_op(c_ALU_ADD, 1'b1, 1'b0, 32'd5, 32'd99, 32'd7, 5'd3);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!wb_valid && lat < 10) begin
         tick();
         lat++;
      end
      chk("t1_latency", 64'(lat),     64'(LAT));
      chk("t1_wb_rd",   64'(wb_rd),   64'd3);
      chk("t1_wb_data", 64'(wb_data), 64'd12);
      chk("t1_wb_zero", 64'(wb_zero), 64'd0);
      tick();

      // Back-pressure: 4 FIFO + issue + wb slots
      wb_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         rand_op(1'b0);
         in_valid = 1'b1;
         if (in_ready) acc++;
         tick();
      end
      in_valid = 1'b0;
      chk("t2_accepted", 64'(acc),      64'd6);
      chk("t2_in_ready", 64'(in_ready), 64'd0);
      chk("t2_count",    64'(count),    64'(DEPTH));
      wb_ready = 1'b1;
      drain("t2_drain");

      // Simultaneous push/pop at count=2, then stream across pointer wrap
      wb_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rand_op(1'b0);
         in_valid = 1'b1;
         tick();
      end
      chk("t3_count_pre", 64'(count), 64'd2);
      wb_ready = 1'b1;
      rand_op(1'b0);
      tick();
      chk("t3_count_pushpop", 64'(count), 64'd2);
      for (int i = 0; i < 2 * DEPTH; i++) begin
         rand_op(1'b0);
         tick();
      end
      in_valid = 1'b0;
      drain("t3_drain");

      // Flush with 3 queued, 1 issue, 1 wb, and a concurrent push
      wb_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rand_op(1'b0);
         in_valid = 1'b1;
         tick();
      end
      chk("t4_count_pre", 64'(count),    64'd3);
      chk("t4_wb_pre",    64'(wb_valid), 64'd1);
      rand_op(1'b0);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("t4_count_post", 64'(count),    64'd0);
      chk("t4_wb_post",    64'(wb_valid), 64'd0);
      wb_ready = 1'b1;
      saw_wb = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (wb_valid) saw_wb = 1'b1;
      end
      chk("t4_no_late_wb", 64'(saw_wb), 64'd0);

      // rd=0 op followed by rd=1 op
      set_op(c_ALU_OR, 1'b0, 1'b0, 32'h0F0, 32'h00F, 32'd0, 5'd0);
      in_valid = 1'b1;
      tick();
      set_op(c_ALU_SUB, 1'b1, 1'b0, 32'd10, 32'd0, 32'd10, 5'd1);
      tick();
      in_valid = 1'b0;
      repeat (LAT - 1) tick();
      chk("t5_rd0_hidden", 64'(wb_valid), 64'd0);
      tick();
      chk("t5_rd1_valid", 64'(wb_valid), 64'd1);
      chk("t5_rd1_rd",    64'(wb_rd),    64'd1);
      chk("t5_rd1_zero",  64'(wb_zero),  64'd1);
      tick();

      // Asynchronous reset while a result is pending
      wb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_op(1'b0);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      chk("t6_wb_pre", 64'(wb_valid), 64'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_wb_valid", 64'(wb_valid), 64'd0);
      chk("t6_count",    64'(count),    64'd0);
      chk("t6_in_ready", 64'(in_ready), 64'd1);
      chk("t6_wb_rd",    64'(wb_rd),    64'd0);
      chk("t6_wb_data",  64'(wb_data),  64'd0);
      chk("t6_imm_ext",  64'(imm_ext),  64'd0);
      #10;
      rst_n = 1'b1;
      tick();
      wb_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_op(1'b0);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      drain("t6_drain");

      // Randomized traffic with back-pressure, rd=0 ops and occasional flush
      for (int i = 0; i < 400; i++) begin
         rand_op(1'b1);
         in_valid = 1'($urandom_range(0, 1));
         wb_ready = ($urandom_range(0, 9) < 7);
         flush    = ($urandom_range(0, 39) == 0);
         tick();
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      wb_ready = 1'b1;
      drain("rand_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
